// File: rtl/sdram_ctrl_pkg.sv
// Shared types and encodings for the SDRAM command engine.
// Holds the FSM state enum, 3-bit {RAS_N,CAS_N,WE_N} command codes,
// command-word field positions and a small helper for timing parameters.
package sdram_ctrl_pkg;

    typedef enum logic [3:0] {
        INIT,
        IDLE,
        FETCH,
        ACTIVATE,
        RCD_WAIT,
        ACCESS,
        CAS_WAIT,
        WR_RECOVER,
        PRECHARGE,
        RP_WAIT,
        REFRESH,
        RFC_WAIT
    } state_t;

    localparam logic [2:0] CMD_NOP       = 3'b111;
    localparam logic [2:0] CMD_ACTIVE    = 3'b011;
    localparam logic [2:0] CMD_READ      = 3'b101;
    localparam logic [2:0] CMD_WRITE     = 3'b100;
    localparam logic [2:0] CMD_PRECHARGE = 3'b010;
    localparam logic [2:0] CMD_REFRESH   = 3'b001;

    localparam int CW_WR      = 40;
    localparam int CW_BANK    = 39;
    localparam int CW_ROW_HI  = 38;
    localparam int CW_ROW_LO  = 35;
    localparam int CW_COL_HI  = 34;
    localparam int CW_COL_LO  = 32;
    localparam int CW_DATA_HI = 31;
    localparam int CW_DATA_LO = 0;

    // A zero timing parameter behaves as a one-cycle wait.
    function automatic int unsigned at_least_one(input int unsigned v);
        return (v == 0) ? 1 : v;
    endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
// Refresh interval timer: raises req every REF_INTERVAL cycles, holds it
// until ack. Ports: HCLK, HRESET (sync, active-high), ack in, req out.
module sdram_refresh_timer
    import sdram_ctrl_pkg::*;
#(
    parameter int unsigned REF_INTERVAL = 780
) (
    input  logic HCLK,
    input  logic HRESET,
    input  logic ack,
    output logic req
);

    localparam int unsigned RI = at_least_one(REF_INTERVAL);
    localparam int unsigned TW = (RI < 2) ? 1 : $clog2(RI);
    localparam logic [TW-1:0] LAST = TW'(RI - 1);

    logic [TW-1:0] cnt;

    // A new interval expiring in the same cycle as ack keeps req set,
    // so that request is not lost.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            cnt <= '0;
            req <= 1'b0;
        end else if (cnt == LAST) begin
            cnt <= '0;
            req <= 1'b1;
        end else begin
            cnt <= cnt + TW'(1);
            if (ack) req <= 1'b0;
        end
    end

endmodule

// File: rtl/sdram_cmd_engine.sv
// SDRAM command engine: pops one command word, runs ACTIVE/READ|WRITE/
// PRECHARGE with programmable timing, pushes read data to a read FIFO.
// Ports: HCLK/HRESET (sync, active-high); CMD_from_FIFO, CmdFIFO_empty,
// CmdFIFO_rd_en (command FIFO); DATA_to_ReadFIFO, ReadFIFO_wr_en,
// ReadFIFO_full (read FIFO); SD_* registered SDRAM pins; INIT_DONE.
// Build option: define SDRAM_AUTO_REFRESH_EN to add periodic auto-refresh.
module sdram_cmd_engine
    import sdram_ctrl_pkg::*;
#(
    parameter int unsigned INIT_CYCLES  = 100,
    parameter int unsigned T_RCD        = 2,
    parameter int unsigned CAS_LAT      = 2,
    parameter int unsigned T_WR         = 2,
    parameter int unsigned T_RP         = 2,
    parameter int unsigned T_RFC        = 6,
    parameter int unsigned REF_INTERVAL = 780
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic [40:0] CMD_from_FIFO,
    input  logic        CmdFIFO_empty,
    output logic        CmdFIFO_rd_en,
    output logic [31:0] DATA_to_ReadFIFO,
    output logic        ReadFIFO_wr_en,
    input  logic        ReadFIFO_full,
    output logic        SD_CS_N,
    output logic        SD_RAS_N,
    output logic        SD_CAS_N,
    output logic        SD_WE_N,
    output logic        SD_BA,
    output logic [3:0]  SD_ADDR,
    output logic [31:0] SD_DQ_OUT,
    output logic        SD_DQ_OE,
    input  logic [31:0] SD_DQ_IN,
    output logic        INIT_DONE
);

    localparam int unsigned INIT_W = at_least_one(INIT_CYCLES);
    localparam int unsigned RCD_W  = at_least_one(T_RCD);
    localparam int unsigned CAS_W  = at_least_one(CAS_LAT);
    localparam int unsigned WR_W   = at_least_one(T_WR);
    localparam int unsigned RP_W   = at_least_one(T_RP);
    localparam int unsigned RFC_W  = at_least_one(T_RFC);
    localparam int CNT_W = 16;

    state_t state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic armed, armed_n;
    logic init_done_n;
    logic [40:0] cmd_q;
    logic ref_pending;
    logic rd_capture;

    logic [2:0]  cmd_d;
    logic        ba_d;
    logic [3:0]  addr_d;
    logic [31:0] dq_d;
    logic        oe_d;

`ifdef SDRAM_AUTO_REFRESH_EN
    logic ref_ack;

    // Pending refresh is cleared once the refresh cycle time has elapsed.
    assign ref_ack = (state == REFRESH || state == RFC_WAIT)
                   && state_n == IDLE;

    sdram_refresh_timer #(
        .REF_INTERVAL(REF_INTERVAL)
    ) u_refresh_timer (
        .HCLK  (HCLK),
        .HRESET(HRESET),
        .ack   (ref_ack),
        .req   (ref_pending)
    );
`else
    assign ref_pending = 1'b0;
`endif

    assign rd_capture = (state == CAS_WAIT) && (cnt == '0);

    // A wait of W cycles spends one cycle in the issuing state and W-1
    // in the wait state; the counter is loaded with W-2 and exits at 0.
    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        armed_n       = armed;
        init_done_n   = INIT_DONE;
        CmdFIFO_rd_en = 1'b0;
        case (state)
            INIT: begin
                // First cycle after reset arms the counter (counter resets to 0).
                if (!armed) begin
                    if (INIT_W == 1) begin
                        state_n = PRECHARGE;
                    end else begin
                        cnt_n   = CNT_W'(INIT_W - 2);
                        armed_n = 1'b1;
                    end
                end else if (cnt == '0) begin
                    state_n = PRECHARGE;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            IDLE: begin
                if (ref_pending) begin
                    state_n = REFRESH;
                end else if (!CmdFIFO_empty && !ReadFIFO_full) begin
                    CmdFIFO_rd_en = 1'b1;
                    state_n       = FETCH;
                end
            end
            FETCH: state_n = ACTIVATE;
            ACTIVATE: begin
                if (RCD_W == 1) begin
                    state_n = ACCESS;
                end else begin
                    cnt_n   = CNT_W'(RCD_W - 2);
                    state_n = RCD_WAIT;
                end
            end
            RCD_WAIT: begin
                if (cnt == '0) state_n = ACCESS;
                else cnt_n = cnt - CNT_W'(1);
            end
            ACCESS: begin
                if (cmd_q[CW_WR]) begin
                    if (WR_W == 1) begin
                        state_n = PRECHARGE;
                    end else begin
                        cnt_n   = CNT_W'(WR_W - 2);
                        state_n = WR_RECOVER;
                    end
                end else begin
                    // Capture happens on the last CAS_WAIT cycle.
                    cnt_n   = CNT_W'(CAS_W - 1);
                    state_n = CAS_WAIT;
                end
            end
            CAS_WAIT: begin
                if (cnt == '0) state_n = PRECHARGE;
                else cnt_n = cnt - CNT_W'(1);
            end
            WR_RECOVER: begin
                if (cnt == '0) state_n = PRECHARGE;
                else cnt_n = cnt - CNT_W'(1);
            end
            PRECHARGE: begin
                if (RP_W == 1) begin
                    state_n     = IDLE;
                    init_done_n = 1'b1;
                end else begin
                    cnt_n   = CNT_W'(RP_W - 2);
                    state_n = RP_WAIT;
                end
            end
            RP_WAIT: begin
                if (cnt == '0) begin
                    state_n     = IDLE;
                    init_done_n = 1'b1;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            REFRESH: begin
                if (RFC_W == 1) begin
                    state_n = IDLE;
                end else begin
                    cnt_n   = CNT_W'(RFC_W - 2);
                    state_n = RFC_WAIT;
                end
            end
            RFC_WAIT: begin
                if (cnt == '0) state_n = IDLE;
                else cnt_n = cnt - CNT_W'(1);
            end
            default: state_n = INIT;
        endcase
    end

    // Pin values are decoded from the next state so the registered pins
    // line up with the state they belong to.
    always_comb begin
        cmd_d  = CMD_NOP;
        ba_d   = 1'b0;
        addr_d = '0;
        dq_d   = '0;
        oe_d   = 1'b0;
        case (state_n)
            ACTIVATE: begin
                // Entered only from FETCH, while the word is on the FIFO port.
                cmd_d  = CMD_ACTIVE;
                ba_d   = CMD_from_FIFO[CW_BANK];
                addr_d = CMD_from_FIFO[CW_ROW_HI:CW_ROW_LO];
            end
            ACCESS: begin
                cmd_d  = cmd_q[CW_WR] ? CMD_WRITE : CMD_READ;
                ba_d   = cmd_q[CW_BANK];
                addr_d = {1'b0, cmd_q[CW_COL_HI:CW_COL_LO]};
                if (cmd_q[CW_WR]) begin
                    dq_d = cmd_q[CW_DATA_HI:CW_DATA_LO];
                    oe_d = 1'b1;
                end
            end
            PRECHARGE: begin
                cmd_d = CMD_PRECHARGE;
                ba_d  = cmd_q[CW_BANK];
            end
            REFRESH: cmd_d = CMD_REFRESH;
            default: cmd_d = CMD_NOP;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state            <= INIT;
            cnt              <= '0;
            armed            <= 1'b0;
            cmd_q            <= '0;
            INIT_DONE        <= 1'b0;
            SD_CS_N          <= 1'b1;
            SD_RAS_N         <= 1'b1;
            SD_CAS_N         <= 1'b1;
            SD_WE_N          <= 1'b1;
            SD_BA            <= 1'b0;
            SD_ADDR          <= '0;
            SD_DQ_OUT        <= '0;
            SD_DQ_OE         <= 1'b0;
            ReadFIFO_wr_en   <= 1'b0;
            DATA_to_ReadFIFO <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            armed     <= armed_n;
            INIT_DONE <= init_done_n;
            if (state == FETCH) cmd_q <= CMD_from_FIFO;
            SD_CS_N   <= ~init_done_n;
            {SD_RAS_N, SD_CAS_N, SD_WE_N} <= cmd_d;
            SD_BA     <= ba_d;
            SD_ADDR   <= addr_d;
            SD_DQ_OUT <= dq_d;
            SD_DQ_OE  <= oe_d;
            ReadFIFO_wr_en <= rd_capture;
            if (rd_capture) DATA_to_ReadFIFO <= SD_DQ_IN;
        end
    end

endmodule

// File: tb/tb_sdram_cmd_engine.sv
// Directed testbench for sdram_cmd_engine (INIT_CYCLES=8, T_RCD=2,
// CAS_LAT=2, T_WR=2, T_RP=2, T_RFC=6, REF_INTERVAL=20).
module tb_sdram_cmd_engine;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic [40:0] CMD_from_FIFO = '0;
    logic        CmdFIFO_empty = 1'b1;
    logic        CmdFIFO_rd_en;
    logic [31:0] DATA_to_ReadFIFO;
    logic        ReadFIFO_wr_en;
    logic        ReadFIFO_full = 1'b0;
    logic        SD_CS_N, SD_RAS_N, SD_CAS_N, SD_WE_N, SD_BA;
    logic [3:0]  SD_ADDR;
    logic [31:0] SD_DQ_OUT;
    logic        SD_DQ_OE;
    logic [31:0] SD_DQ_IN = '0;
    logic        INIT_DONE;
    logic [2:0]  sd_cmd;

    int checks = 0;
    int errors = 0;

    assign sd_cmd = {SD_RAS_N, SD_CAS_N, SD_WE_N};

    always #5 HCLK = ~HCLK;

    sdram_cmd_engine #(
        .INIT_CYCLES(8), .T_RCD(2), .CAS_LAT(2), .T_WR(2),
        .T_RP(2), .T_RFC(6), .REF_INTERVAL(20)
    ) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .CMD_from_FIFO(CMD_from_FIFO), .CmdFIFO_empty(CmdFIFO_empty),
        .CmdFIFO_rd_en(CmdFIFO_rd_en),
        .DATA_to_ReadFIFO(DATA_to_ReadFIFO), .ReadFIFO_wr_en(ReadFIFO_wr_en),
        .ReadFIFO_full(ReadFIFO_full),
        .SD_CS_N(SD_CS_N), .SD_RAS_N(SD_RAS_N), .SD_CAS_N(SD_CAS_N),
        .SD_WE_N(SD_WE_N), .SD_BA(SD_BA), .SD_ADDR(SD_ADDR),
        .SD_DQ_OUT(SD_DQ_OUT), .SD_DQ_OE(SD_DQ_OE), .SD_DQ_IN(SD_DQ_IN),
        .INIT_DONE(INIT_DONE)
    );

    task automatic step;
        @(posedge HCLK);
        #2;
    endtask

    task automatic test_reset;
        HRESET = 1'b1;
        repeat (3) step;
        checks++;
        if (SD_CS_N !== 1'b1) begin
            errors++; $display("FAIL reset_cs_n: got %0h want 1", SD_CS_N);
        end
        checks++;
        if (sd_cmd !== 3'b111) begin
            errors++; $display("FAIL reset_cmd: got %b want 111", sd_cmd);
        end
        checks++;
        if (INIT_DONE !== 1'b0) begin
            errors++; $display("FAIL reset_init_done: got %0h want 0", INIT_DONE);
        end
        checks++;
        if ({ReadFIFO_wr_en, CmdFIFO_rd_en, SD_DQ_OE} !== 3'b000) begin
            errors++;
            $display("FAIL reset_strobes: got %b want 000",
                     {ReadFIFO_wr_en, CmdFIFO_rd_en, SD_DQ_OE});
        end
        checks++;
        if ({SD_BA, SD_ADDR, SD_DQ_OUT, DATA_to_ReadFIFO} !== 69'd0) begin
            errors++;
            $display("FAIL reset_buses: got %0h/%0h/%0h/%0h want 0",
                     SD_BA, SD_ADDR, SD_DQ_OUT, DATA_to_ReadFIFO);
        end
    endtask

    // Releases reset with a write word already waiting in the FIFO.
    task automatic test_init;
        logic [2:0] exp;
        CMD_from_FIFO = {1'b1, 1'b1, 4'hA, 3'h5, 32'hDEADBEEF};
        CmdFIFO_empty = 1'b0;
        HRESET = 1'b0;
        #1;
        for (int i = 0; i <= 9; i++) begin
            if (i != 0) step;
            exp = (i == 8) ? 3'b010 : 3'b111;
            checks++;
            if (sd_cmd !== exp || SD_CS_N !== 1'b1 || INIT_DONE !== 1'b0
                || CmdFIFO_rd_en !== 1'b0) begin
                errors++;
                $display("FAIL init_cycle%0d: got cmd=%b cs=%b done=%b rd=%b want cmd=%b cs=1 done=0 rd=0",
                         i, sd_cmd, SD_CS_N, INIT_DONE, CmdFIFO_rd_en, exp);
            end
        end
        step;
        checks++;
        if (INIT_DONE !== 1'b1 || SD_CS_N !== 1'b0 || sd_cmd !== 3'b111) begin
            errors++;
            $display("FAIL init_done: got done=%b cs=%b cmd=%b want 1 0 111",
                     INIT_DONE, SD_CS_N, sd_cmd);
        end
        checks++;
        if (CmdFIFO_rd_en !== 1'b1) begin
            errors++; $display("FAIL init_first_pop: got %b want 1", CmdFIFO_rd_en);
        end
    endtask

    task automatic test_write;
        step;
        CmdFIFO_empty = 1'b1;
        checks++;
        if (sd_cmd !== 3'b111) begin
            errors++; $display("FAIL wr_fetch_nop: got %b want 111", sd_cmd);
        end
        step;
        checks++;
        if (sd_cmd !== 3'b011 || SD_BA !== 1'b1 || SD_ADDR !== 4'hA) begin
            errors++;
            $display("FAIL wr_active: got cmd=%b ba=%b addr=%h want 011 1 a",
                     sd_cmd, SD_BA, SD_ADDR);
        end
        step;
        checks++;
        if (sd_cmd !== 3'b111) begin
            errors++; $display("FAIL wr_rcd_nop: got %b want 111", sd_cmd);
        end
        step;
        checks++;
        if (sd_cmd !== 3'b100 || SD_ADDR !== 4'h5 || SD_DQ_OUT !== 32'hDEADBEEF
            || SD_DQ_OE !== 1'b1) begin
            errors++;
            $display("FAIL wr_write: got cmd=%b addr=%h dq=%h oe=%b want 100 5 deadbeef 1",
                     sd_cmd, SD_ADDR, SD_DQ_OUT, SD_DQ_OE);
        end
        step;
        checks++;
        if (sd_cmd !== 3'b111 || SD_DQ_OE !== 1'b0) begin
            errors++;
            $display("FAIL wr_recover: got cmd=%b oe=%b want 111 0", sd_cmd, SD_DQ_OE);
        end
        step;
        checks++;
        if (sd_cmd !== 3'b010) begin
            errors++; $display("FAIL wr_precharge: got %b want 010", sd_cmd);
        end
        step;
        step;
    endtask

    task automatic test_read;
        CMD_from_FIFO = {1'b0, 1'b0, 4'h3, 3'h2, 32'h0};
        CmdFIFO_empty = 1'b0;
        #1;
        checks++;
        if (CmdFIFO_rd_en !== 1'b1) begin
            errors++; $display("FAIL rd_pop: got %b want 1", CmdFIFO_rd_en);
        end
        step;
        CmdFIFO_empty = 1'b1;
        step;
        checks++;
        if (sd_cmd !== 3'b011 || SD_BA !== 1'b0 || SD_ADDR !== 4'h3) begin
            errors++;
            $display("FAIL rd_active: got cmd=%b ba=%b addr=%h want 011 0 3",
                     sd_cmd, SD_BA, SD_ADDR);
        end
        step;
        step;
        checks++;
        if (sd_cmd !== 3'b101 || SD_ADDR !== 4'h2 || SD_DQ_OE !== 1'b0) begin
            errors++;
            $display("FAIL rd_read: got cmd=%b addr=%h oe=%b want 101 2 0",
                     sd_cmd, SD_ADDR, SD_DQ_OE);
        end
        step;
        SD_DQ_IN = 32'hBAD0BAD0;
        step;
        SD_DQ_IN = 32'h12345678;
        checks++;
        if (ReadFIFO_wr_en !== 1'b0) begin
            errors++; $display("FAIL rd_early_push: got %b want 0", ReadFIFO_wr_en);
        end
        step;
        SD_DQ_IN = 32'hFFFFFFFF;
        checks++;
        if (ReadFIFO_wr_en !== 1'b1 || DATA_to_ReadFIFO !== 32'h12345678
            || sd_cmd !== 3'b010) begin
            errors++;
            $display("FAIL rd_push: got wr=%b data=%h cmd=%b want 1 12345678 010",
                     ReadFIFO_wr_en, DATA_to_ReadFIFO, sd_cmd);
        end
        step;
        checks++;
        if (ReadFIFO_wr_en !== 1'b0) begin
            errors++; $display("FAIL rd_push_width: got %b want 0", ReadFIFO_wr_en);
        end
        step;
    endtask

    task automatic test_full_backpressure;
        int pushes = 0;
        ReadFIFO_full = 1'b1;
        CMD_from_FIFO = {1'b0, 1'b1, 4'h5, 3'h7, 32'h0};
        CmdFIFO_empty = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (CmdFIFO_rd_en !== 1'b0) begin
                errors++; $display("FAIL full_no_pop%0d: got %b want 0", i, CmdFIFO_rd_en);
            end
            step;
        end
        ReadFIFO_full = 1'b0;
        #1;
        checks++;
        if (CmdFIFO_rd_en !== 1'b1) begin
            errors++; $display("FAIL full_release_pop: got %b want 1", CmdFIFO_rd_en);
        end
        step;
        CmdFIFO_empty = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step;
            if (ReadFIFO_wr_en === 1'b1) pushes++;
        end
        checks++;
        if (pushes != 1) begin
            errors++; $display("FAIL full_read_pushes: got %0d want 1", pushes);
        end
    endtask

    task automatic test_reset_mid;
        logic [2:0] exp;
        CMD_from_FIFO = {1'b0, 1'b0, 4'h1, 3'h1, 32'h0};
        CmdFIFO_empty = 1'b0;
        step;
        CmdFIFO_empty = 1'b1;
        repeat (4) step;
        HRESET = 1'b1;
        step;
        checks++;
        if (ReadFIFO_wr_en !== 1'b0 || sd_cmd !== 3'b111 || SD_CS_N !== 1'b1
            || INIT_DONE !== 1'b0 || DATA_to_ReadFIFO !== 32'h0) begin
            errors++;
            $display("FAIL midrst_outputs: got wr=%b cmd=%b cs=%b done=%b data=%h want 0 111 1 0 0",
                     ReadFIFO_wr_en, sd_cmd, SD_CS_N, INIT_DONE, DATA_to_ReadFIFO);
        end
        HRESET = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            step;
            exp = (i == 8) ? 3'b010 : 3'b111;
            checks++;
            if (ReadFIFO_wr_en !== 1'b0 || sd_cmd !== exp || INIT_DONE !== 1'b0) begin
                errors++;
                $display("FAIL midrst_cycle%0d: got wr=%b cmd=%b done=%b want 0 %b 0",
                         i, ReadFIFO_wr_en, sd_cmd, INIT_DONE, exp);
            end
        end
        step;
        checks++;
        if (INIT_DONE !== 1'b1) begin
            errors++; $display("FAIL midrst_init_done: got %b want 1", INIT_DONE);
        end
    endtask

`ifdef SDRAM_AUTO_REFRESH_EN
    task automatic test_refresh;
        localparam int N = 8;
        int pops = 0;
        int writes = 0;
        int refs = 0;
        int last_ref = -100;
        bit in_flight = 0;
        bit pend = 0;
        bit rd;
        logic [31:0] d;
        d = 32'hC0DE0000;
        CMD_from_FIFO = {1'b1, 1'b0, 4'h0, 3'h0, d};
        CmdFIFO_empty = 1'b0;
        for (int cyc = 0; cyc < 400 && writes < N; cyc++) begin
            #1;
            rd = CmdFIFO_rd_en;
            if (sd_cmd === 3'b001) begin
                refs++;
                checks++;
                if (in_flight) begin
                    errors++; $display("FAIL ref_in_flight: cycle %0d got refresh want idle", cyc);
                end
                last_ref = cyc;
            end else if (cyc - last_ref < 6) begin
                checks++;
                if (rd || sd_cmd !== 3'b111) begin
                    errors++;
                    $display("FAIL ref_gap: cycle %0d got rd=%b cmd=%b want 0 111",
                             cyc, rd, sd_cmd);
                end
            end
            if (sd_cmd === 3'b011) in_flight = 1;
            if (sd_cmd === 3'b010) in_flight = 0;
            if (sd_cmd === 3'b100) begin
                d = 32'hC0DE0000 + 32'(writes);
                checks++;
                if (SD_DQ_OUT !== d) begin
                    errors++; $display("FAIL ref_wdata%0d: got %h want %h", writes, SD_DQ_OUT, d);
                end
                writes++;
            end
            if (rd) pops++;
            step;
            if (pend) begin
                d = 32'hC0DE0000 + 32'(pops);
                CMD_from_FIFO = {1'b1, 1'b0, 4'(pops), 3'(pops), d};
                CmdFIFO_empty = (pops >= N);
            end
            pend = rd;
        end
        CmdFIFO_empty = 1'b1;
        checks++;
        if (writes != N || pops != N) begin
            errors++; $display("FAIL ref_lost_cmds: got writes=%0d pops=%0d want %0d", writes, pops, N);
        end
        checks++;
        if (refs < 1) begin
            errors++; $display("FAIL ref_count: got %0d want >=1", refs);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_init;
        test_write;
        test_read;
        test_full_backpressure;
        test_reset_mid;
`ifdef SDRAM_AUTO_REFRESH_EN
        test_refresh;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
